// File: rtl/gpio_shift_out.sv
// Serializes the 32-bit GPIO output state onto a chain of 74HC595-style shift registers.
// Optional GPIO_SHIFT_LSB_FIRST_EN: shift bit 0 first instead of bit 31.
module gpio_shift_out #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] state,
  output logic        sclk,
  output logic        sdata,
  output logic        latch,
  output logic        busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT_LO = 2'd1;
  localparam logic [1:0] SHIFT_HI = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [1:0]  fsm;
  logic [31:0] sent;
  logic [31:0] shadow;
  logic        pending;
  logic [5:0]  bitcnt;
  logic [7:0]  divcnt;
  logic        div_done;

  assign div_done = (divcnt == DIV_LAST);

  // Maps the shift position to the state bit presented on sdata.
  function automatic logic [4:0] bit_idx(input logic [4:0] cnt);
`ifdef GPIO_SHIFT_LSB_FIRST_EN
    return cnt;
`else
    return 5'd31 - cnt;
`endif
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of sent/shadow/bitcnt regardless of statement order.
    if (!rst_n) begin
      fsm     <= IDLE;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      sent    <= '0;
      shadow  <= '0;
      pending <= 1'b1;
      bitcnt  <= '0;
      divcnt  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (state != sent || pending) begin
            shadow  <= state;
            pending <= 1'b0;
            busy    <= 1'b1;
            bitcnt  <= '0;
            divcnt  <= '0;
            sdata   <= state[bit_idx(5'd0)];
            fsm     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_done) begin
            divcnt <= '0;
            sclk   <= 1'b1;
            fsm    <= SHIFT_HI;
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            divcnt <= '0;
            sclk   <= 1'b0;
            if (bitcnt == 6'd31) begin
              latch <= 1'b1;
              fsm   <= LATCH;
            end else begin
              // Data only moves on the falling sclk transition.
              bitcnt <= bitcnt + 6'd1;
              sdata  <= shadow[bit_idx(bitcnt[4:0] + 5'd1)];
              fsm    <= SHIFT_LO;
            end
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end
        LATCH: begin
          if (div_done) begin
            divcnt <= '0;
            latch  <= 1'b0;
            busy   <= 1'b0;
            sdata  <= 1'b0;
            sent   <= shadow;
            fsm    <= IDLE;
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
